// File: rtl/lc3_bus_pkg.sv
// Shared types and helpers for the LC-3 bus arbiter: state encoding, default sizes,
// and a one-hot to index encoder.
package lc3_bus_pkg;

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} bus_state_t;

  localparam int WIDTH_DEF = 16;
  localparam int N_SRC_DEF = 4;

  // OR-reduction encoder; assumes at most one bit of oh is set
  function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
    int unsigned idx;
    idx = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) begin
        idx = idx | unsigned'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/lc3_bus_arbiter_rr.sv
// Combinational bus arbiter: round-robin search from ptr+1, or fixed lowest-index
// priority, producing a one-hot grant, its index and a contention flag.
module rr_arbiter
  import lc3_bus_pkg::*;
#(
  parameter int N_SRC   = 4,
  parameter int RR_MODE = 1,
  localparam int IDX_W  = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N_SRC-1:0] grant,
  output logic [IDX_W-1:0] index,
  output logic             multi
);

  logic [IDX_W-1:0] pos_s;
  logic             found_s;

  // first requester in search order takes the bus
  always_comb begin
    grant   = '0;
    pos_s   = '0;
    found_s = 1'b0;
    if (en) begin
      for (int k = 0; k < N_SRC; k++) begin
        if (RR_MODE != 0) begin
          pos_s = IDX_W'((int'(ptr) + 1 + k) % N_SRC);
        end else begin
          pos_s = IDX_W'(k);
        end
        if (req[pos_s] && !found_s) begin
          grant[pos_s] = 1'b1;
          found_s      = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
    end else begin
      grant = '0;
    end
  end

  // index and contention flag derived from grant and request vector
  always_comb begin
    index = IDX_W'(onehot_to_idx(32'(grant)));
    multi = ($countones(req) > 1);
  end

endmodule

// File: rtl/lc3_bus_arbiter.sv
// Registered shared-bus arbiter: grants one requesting source per cycle, holds the
// captured word behind a valid/ready handshake and counts contended captures.
module lc3_bus_arbiter
  import lc3_bus_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int N_SRC   = N_SRC_DEF,
  parameter int RR_MODE = 1,
  parameter int CNT_W   = 8,
  localparam int IDX_W  = $clog2(N_SRC)
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [N_SRC-1:0]            Req,
  input  logic [N_SRC-1:0][WIDTH-1:0] Data,
  output logic [N_SRC-1:0]            Grant,
  output logic                        Out_valid,
  input  logic                        Out_ready,
  output logic [WIDTH-1:0]            Out_data,
  output logic [IDX_W-1:0]            Out_src,
  input  logic                        Clr_stats,
  output logic [CNT_W-1:0]            Contention_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  bus_state_t       state_r, state_nx_s;
  logic             can_load_s, capture_s, multi_s;
  logic [N_SRC-1:0] grant_s;
  logic [IDX_W-1:0] idx_s, ptr_r, src_r;
  logic [WIDTH-1:0] data_r;
  logic [CNT_W-1:0] cnt_r;

  assign can_load_s = (state_r == S_EMPTY) || Out_ready;
  assign capture_s  = |grant_s;

  // grant is gated by reset so nothing is offered while the block is held
  rr_arbiter #(.N_SRC(N_SRC), .RR_MODE(RR_MODE)) u_arb (
    .req   (Req),
    .ptr   (ptr_r),
    .en    (can_load_s && Reset),
    .grant (grant_s),
    .index (idx_s),
    .multi (multi_s)
  );

  // state register
  always_ff @(posedge Clk) begin
    if (!Reset) state_r <= S_EMPTY;
    else        state_r <= state_nx_s;
  end

  // next-state: a capture always leaves the register full
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_EMPTY: state_nx_s = capture_s ? S_FULL : S_EMPTY;
      S_FULL:  state_nx_s = (Out_ready && !capture_s) ? S_EMPTY : S_FULL;
      default: state_nx_s = S_EMPTY;
    endcase
  end

  // outputs
  always_comb begin
    Grant          = grant_s;
    Out_valid      = (state_r == S_FULL);
    Out_data       = data_r;
    Out_src        = src_r;
    Contention_cnt = cnt_r;
  end

  // output word, source tag and round-robin pointer update on capture only
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      data_r <= '0;
      src_r  <= '0;
      ptr_r  <= IDX_W'(N_SRC - 1);
    end else if (capture_s) begin
      data_r <= Data[idx_s];
      src_r  <= idx_s;
      ptr_r  <= idx_s;
    end
  end

  // saturating contention counter; clear dominates a coincident increment
  always_ff @(posedge Clk) begin
    if (!Reset || Clr_stats) cnt_r <= '0;
    else if (capture_s && multi_s && (cnt_r != CNT_MAX)) cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: tb/tb_lc3_bus_arbiter.sv
// Directed bench: one round-robin instance and one fixed-priority instance with a
// 2-bit counter; captured words are checked against scoreboard queues.
module tb_lc3_bus_arbiter;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0][15:0] data = '0;
  logic [3:0]       req_a = '0, req_b = '0, grant_a, grant_b;
  logic             rdy_a = 1'b0, rdy_b = 1'b0, clr_a = 1'b0, clr_b = 1'b0;
  logic             valid_a, valid_b;
  logic [15:0]      odata_a, odata_b;
  logic [1:0]       osrc_a, osrc_b;
  logic [7:0]       cnt_a;
  logic [1:0]       cnt_b;
  logic [17:0]      sb_a[$], sb_b[$];
  int               vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  lc3_bus_arbiter dut_a (
    .Clk(clk), .Reset(rst_n), .Req(req_a), .Data(data), .Grant(grant_a),
    .Out_valid(valid_a), .Out_ready(rdy_a), .Out_data(odata_a), .Out_src(osrc_a),
    .Clr_stats(clr_a), .Contention_cnt(cnt_a));

  lc3_bus_arbiter #(.RR_MODE(0), .CNT_W(2)) dut_b (
    .Clk(clk), .Reset(rst_n), .Req(req_b), .Data(data), .Grant(grant_b),
    .Out_valid(valid_b), .Out_ready(rdy_b), .Out_data(odata_b), .Out_src(osrc_b),
    .Clr_stats(clr_b), .Contention_cnt(cnt_b));

  function automatic logic [1:0] oh2i(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit sel_b, input logic rs, input logic [3:0] r, input logic rd,
                     input logic cl, input logic [3:0] eg);
    logic [1:0] ix;
    @(posedge clk);
    #1;
    rst_n = rs;
    if (sel_b) begin req_b = r; rdy_b = rd; clr_b = cl; end
    else       begin req_a = r; rdy_a = rd; clr_a = cl; end
    @(negedge clk);
    ix = oh2i(eg);
    if (sel_b) chk("grant_b", 32'(grant_b), 32'(eg));
    else       chk("grant_a", 32'(grant_a), 32'(eg));
    if (eg != 4'd0) begin
      if (sel_b) sb_b.push_back({ix, data[ix]});
      else       sb_a.push_back({ix, data[ix]});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // scoreboard monitor: an accepted word must match the oldest expected entry
    fork
      forever begin
        @(negedge clk);
        if (rst_n && valid_a && rdy_a) begin
          if (sb_a.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL sb_a_extra: got word %h expected none", odata_a);
          end else chk("sb_a_word", 32'({osrc_a, odata_a}), 32'(sb_a.pop_front()));
        end
        if (rst_n && valid_b && rdy_b) begin
          if (sb_b.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL sb_b_extra: got word %h expected none", odata_b);
          end else chk("sb_b_word", 32'({osrc_b, odata_b}), 32'(sb_b.pop_front()));
        end
      end
    join_none

    data[0] = 16'h0A0A; data[1] = 16'hBEEF; data[2] = 16'h1234; data[3] = 16'hC0DE;

    // reset state, then fill with BEEF and reset mid-FULL
    cyc(0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_data", 32'(odata_a), 32'd0);
    cyc(0, 1'b1, 4'b0010, 1'b0, 1'b0, 4'b0010);
    cyc(0, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000);
    chk("full_valid", 32'(valid_a), 32'd1);
    chk("full_data", 32'(odata_a), 32'hBEEF);
    cyc(0, 1'b0, 4'b1111, 1'b1, 1'b0, 4'b0000);
    sb_a.delete();
    cyc(0, 1'b0, 4'b1111, 1'b1, 1'b0, 4'b0000);
    chk("rst2_valid", 32'(valid_a), 32'd0);
    chk("rst2_data", 32'(odata_a), 32'd0);
    chk("rst2_cnt", 32'(cnt_a), 32'd0);
    cyc(0, 1'b1, 4'b0001, 1'b1, 1'b0, 4'b0001);

    // single request from source 2, 1-cycle latency to the output
    cyc(0, 1'b1, 4'b0100, 1'b1, 1'b0, 4'b0100);
    cyc(0, 1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000);
    chk("lat_valid", 32'(valid_a), 32'd1);
    chk("lat_data", 32'(odata_a), 32'h1234);
    chk("lat_src", 32'(osrc_a), 32'd2);

    // park pointer at 3, then round-robin over all four requesters
    cyc(0, 1'b1, 4'b1000, 1'b1, 1'b0, 4'b1000);
    for (int i = 0; i < 8; i++) cyc(0, 1'b1, 4'b1111, 1'b1, 1'b0, 4'b0001 << (i % 4));
    cyc(0, 1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000);
    chk("rr_cnt", 32'(cnt_a), 32'd8);
    cyc(0, 1'b1, 4'b0000, 1'b1, 1'b1, 4'b0000);
    cyc(0, 1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000);
    chk("clr_cnt", 32'(cnt_a), 32'd0);

    // stall with the register full, then accept plus capture in one cycle
    cyc(0, 1'b1, 4'b0100, 1'b0, 1'b0, 4'b0100);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1'b1, 4'b0001, 1'b0, 1'b0, 4'b0000);
      chk("stall_data", 32'(odata_a), 32'h1234);
      chk("stall_valid", 32'(valid_a), 32'd1);
    end
    cyc(0, 1'b1, 4'b0001, 1'b1, 1'b0, 4'b0001);
    cyc(0, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000);
    chk("b2b_valid", 32'(valid_a), 32'd1);
    chk("b2b_data", 32'(odata_a), 32'h0A0A);
    chk("b2b_src", 32'(osrc_a), 32'd0);
    cyc(0, 1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000);
    cyc(0, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000);
    chk("drain_valid", 32'(valid_a), 32'd0);

    // fixed priority with a 2-bit saturating counter
    for (int i = 0; i < 5; i++) cyc(1, 1'b1, 4'b1010, 1'b1, 1'b0, 4'b0010);
    cyc(1, 1'b1, 4'b1010, 1'b1, 1'b1, 4'b0010);
    chk("sat_cnt", 32'(cnt_b), 32'd3);
    cyc(1, 1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000);
    chk("clr_wins", 32'(cnt_b), 32'd0);
    cyc(1, 1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000);
    chk("b_drain_valid", 32'(valid_b), 32'd0);

    cyc(1, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000);
    chk("sb_a_left", 32'(sb_a.size()), 32'd0);
    chk("sb_b_left", 32'(sb_b.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
